// File: rtl/bayer_pkg.sv
// Shared constants and helpers for the Bayer 2x2 binning / greyscale path.
package bayer_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int OUT_W      = DEF_IMG_W / 2;
    localparam int OUT_H      = DEF_IMG_H / 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Averages a four-pixel sum; rounding adds half of the result LSB before the shift.
    function automatic logic [31:0] greyRound(input logic [31:0] sum, input logic roundEn);
        return roundEn ? ((sum + 32'd2) >> 2) : (sum >> 2);
    endfunction

endpackage

// File: rtl/bayer_bin_gray_if.sv
// Raw pixel stream in, binned grey stream out.
// THRESHOLD_EN adds the binarisation threshold input and oBin output.
interface bayer_bin_gray_if
    import bayer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int XW     = clog2(OUT_W),
    parameter int YW     = clog2(OUT_H)
);

    logic              iSOF;
    logic              iDVAL;
    logic [DATA_W-1:0] iDATA;
    logic [DATA_W-1:0] oGrey;
    logic              oDVAL;
    logic [XW-1:0]     oX;
    logic [YW-1:0]     oY;
    logic              oEdge;
    logic              oEOF;
`ifdef THRESHOLD_EN
    logic [DATA_W-1:0] iTHRESH;
    logic              oBin;

    modport master (output iSOF, iDVAL, iDATA, iTHRESH,
                    input  oGrey, oDVAL, oX, oY, oEdge, oEOF, oBin);
    modport slave  (input  iSOF, iDVAL, iDATA, iTHRESH,
                    output oGrey, oDVAL, oX, oY, oEdge, oEOF, oBin);
`else
    modport master (output iSOF, iDVAL, iDATA,
                    input  oGrey, oDVAL, oX, oY, oEdge, oEOF);
    modport slave  (input  iSOF, iDVAL, iDATA,
                    output oGrey, oDVAL, oX, oY, oEdge, oEOF);
`endif

endinterface

// File: rtl/bayer_line_buf.sv
// One-line pixel store: synchronous read-before-write, clock-enabled, block-RAM friendly.
module bayer_line_buf #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int AW     = 10
) (
    input  logic              iCLK,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge iCLK) begin
        if (en) begin
            rdData    <= mem[addr];
            mem[addr] <= wrData;
        end
    end

endmodule

// File: rtl/bayer_bin_gray.sv
// Bayer-to-grey converter with 2x2 binning, self-generated pixel/line counters and border/EOF flags.
// Define THRESHOLD_EN to add the registered binarised output oBin (oGrey >= iTHRESH).
module bayer_bin_gray
    import bayer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ROUND  = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    bayer_bin_gray_if.slave   bus
);

    localparam int XW    = clog2(IMG_W);
    localparam int YW    = clog2(IMG_H);
    localparam int COLS  = IMG_W / 2;
    localparam int ROWS  = IMG_H / 2;
    localparam int OXW   = clog2(COLS);
    localparam int OYW   = clog2(ROWS);
    localparam int SUM_W = DATA_W + 2;

    logic [XW-1:0]     xCnt;
    logic [YW-1:0]     yCnt;
    logic [XW-1:0]     pixX;
    logic [YW-1:0]     pixY;
    logic              completes;
    logic [DATA_W-1:0] rowAbove;
    logic [DATA_W-1:0] heldPix;

    logic              s1Valid;
    logic [SUM_W-1:0]  s1Partial;
    logic [OXW-1:0]    s1X;
    logic [OYW-1:0]    s1Y;
`ifdef THRESHOLD_EN
    logic [DATA_W-1:0] s1Thresh;
`endif

    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] greyNext;
    logic              onBorder;
    logic              lastPix;

    // A start-of-frame pixel is always (0,0) regardless of where the counters stood.
    assign pixX      = bus.iSOF ? '0 : xCnt;
    assign pixY      = bus.iSOF ? '0 : yCnt;
    assign completes = bus.iDVAL & pixX[0] & pixY[0];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (bus.iDVAL) begin
            if (pixX == XW'(IMG_W - 1)) begin
                xCnt <= '0;
                yCnt <= (pixY == YW'(IMG_H - 1)) ? '0 : pixY + YW'(1);
            end else begin
                xCnt <= pixX + XW'(1);
                yCnt <= pixY;
            end
        end else if (bus.iSOF) begin
            xCnt <= '0;
            yCnt <= '0;
        end
    end

    bayer_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (XW)
    ) lineBuf (
        .iCLK   (iCLK),
        .en     (bus.iDVAL),
        .addr   (pixX),
        .wrData (bus.iDATA),
        .rdData (rowAbove)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            heldPix <= '0;
        end else if (bus.iDVAL) begin
            heldPix <= bus.iDATA;
        end
    end

    // Stage 1 adds the three pixels known now; the top-right one emerges from the RAM a cycle later.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1Valid   <= 1'b0;
            s1Partial <= '0;
            s1X       <= '0;
            s1Y       <= '0;
`ifdef THRESHOLD_EN
            s1Thresh  <= '0;
`endif
        end else begin
            s1Valid <= completes;
            if (completes) begin
                s1Partial <= SUM_W'(rowAbove) + SUM_W'(heldPix) + SUM_W'(bus.iDATA);
                s1X       <= pixX[XW-1:1];
                s1Y       <= pixY[YW-1:1];
`ifdef THRESHOLD_EN
                s1Thresh  <= bus.iTHRESH;
`endif
            end
        end
    end

    assign sum      = s1Partial + SUM_W'(rowAbove);
    assign greyNext = DATA_W'(greyRound(32'(sum), ROUND != 0));
    assign onBorder = (s1X == '0) || (s1Y == '0) ||
                      (s1X == OXW'(COLS - 1)) || (s1Y == OYW'(ROWS - 1));
    assign lastPix  = (s1X == OXW'(COLS - 1)) && (s1Y == OYW'(ROWS - 1));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bus.oDVAL <= 1'b0;
            bus.oGrey <= '0;
            bus.oX    <= '0;
            bus.oY    <= '0;
            bus.oEdge <= 1'b0;
            bus.oEOF  <= 1'b0;
`ifdef THRESHOLD_EN
            bus.oBin  <= 1'b0;
`endif
        end else begin
            bus.oDVAL <= s1Valid;
            if (s1Valid) begin
                bus.oGrey <= greyNext;
                bus.oX    <= s1X;
                bus.oY    <= s1Y;
                bus.oEdge <= onBorder;
                bus.oEOF  <= lastPix;
`ifdef THRESHOLD_EN
                bus.oBin  <= (greyNext >= s1Thresh);
`endif
            end
        end
    end

endmodule

// File: tb/tb_bayer_bin_gray.sv
// Bench for bayer_bin_gray on an 8x6 image: a truncating and a rounding instance share one stream.
// With THRESHOLD_EN defined the oBin outputs are checked as well.
module tb_bayer_bin_gray;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 12;
    localparam int XW = 2;
    localparam int YW = 2;

    typedef struct {
        int        due;
        logic [11:0] g0;
        logic [11:0] g1;
        logic [1:0]  ex;
        logic [1:0]  ey;
        logic        onEdge;
        logic        eof;
        logic        bin0;
        logic        bin1;
    } expT;

    logic iCLK;
    logic iRST;
    int   cyc = 0;
    int   checkCount = 0;
    int   passCount = 0;
    bit   monitorOn = 1'b0;
    int   mx = 0;
    int   my = 0;
    logic [11:0] img [H][W];
    logic [11:0] thresh = 12'h400;
    expT  q[$];

    bayer_bin_gray_if #(.DATA_W(DW), .XW(XW), .YW(YW)) bus0 ();
    bayer_bin_gray_if #(.DATA_W(DW), .XW(XW), .YW(YW)) bus1 ();

    assign bus1.iSOF  = bus0.iSOF;
    assign bus1.iDVAL = bus0.iDVAL;
    assign bus1.iDATA = bus0.iDATA;
`ifdef THRESHOLD_EN
    assign bus1.iTHRESH = bus0.iTHRESH;
`endif

    bayer_bin_gray #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ROUND(0)) dut0 (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus0.slave)
    );

    bayer_bin_gray #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ROUND(1)) dut1 (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus1.slave)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "[TB] bench timed out");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checkCount++;
        assert (obs === expd) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expd);
    endtask

    function automatic logic [11:0] pixVal(input int mode, input int x, input int y);
        logic [11:0] v;
        v = 12'($urandom);
        case (mode)
            0: v = 12'h800;
            2: v = 12'hFFF;
            3: v = ((x / 2) % 2 == 1) ? 12'h400 : 12'h3FF;
            default: begin
                if (y == 0 && x == 0) v = 12'd100;
                if (y == 0 && x == 1) v = 12'd200;
                if (y == 1 && x == 0) v = 12'd201;
                if (y == 1 && x == 1) v = 12'd303;
                if (y <= 1 && (x == 2 || x == 3 || x == 4 || x == 5)) v = 12'd1;
                if (y == 1 && x == 3) v = 12'd2;
                if (y == 1 && x == 5) v = 12'd3;
            end
        endcase
        return v;
    endfunction

    // Drives one cycle of input and records the expected output of any quad it completes.
    task automatic applyStimulus(input logic sof, input logic dval, input logic [11:0] data);
        expT e;
        int  s;
        bus0.iSOF  = sof;
        bus0.iDVAL = dval;
        bus0.iDATA = data;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        if (dval) begin
            img[my][mx] = data;
            if (mx % 2 == 1 && my % 2 == 1) begin
                s = int'(img[my-1][mx-1]) + int'(img[my-1][mx]) + int'(img[my][mx-1]) + int'(data);
                e.due    = cyc + 2;
                e.g0     = 12'(s >> 2);
                e.g1     = 12'((s + 2) >> 2);
                e.ex     = 2'(mx / 2);
                e.ey     = 2'(my / 2);
                e.onEdge = (mx / 2 == 0) || (my / 2 == 0) || (mx / 2 == W/2 - 1) || (my / 2 == H/2 - 1);
                e.eof    = (mx / 2 == W/2 - 1) && (my / 2 == H/2 - 1);
                e.bin0   = (e.g0 >= thresh);
                e.bin1   = (e.g1 >= thresh);
                q.push_back(e);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        @(posedge iCLK);
        #1;
        bus0.iSOF  = 1'b0;
        bus0.iDVAL = 1'b0;
    endtask

    task automatic sendFrame(input int mode, input int gapMax, input int stopX, input int stopY,
                             input logic useSof);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == stopX && y == stopY) return;
                if (!(x == 0 && y == 0))
                    repeat ($urandom_range(gapMax, 0)) applyStimulus(1'b0, 1'b0, 12'($urandom));
                applyStimulus(useSof && x == 0 && y == 0, 1'b1, pixVal(mode, x, y));
            end
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_oDVAL_trunc", bus0.oDVAL, 0);
        checkOutput("rst_oGrey_trunc", bus0.oGrey, 0);
        checkOutput("rst_oX_trunc",    bus0.oX,    0);
        checkOutput("rst_oY_trunc",    bus0.oY,    0);
        checkOutput("rst_oEdge_trunc", bus0.oEdge, 0);
        checkOutput("rst_oEOF_trunc",  bus0.oEOF,  0);
        checkOutput("rst_oDVAL_round", bus1.oDVAL, 0);
        checkOutput("rst_oGrey_round", bus1.oGrey, 0);
        checkOutput("rst_oX_round",    bus1.oX,    0);
        checkOutput("rst_oY_round",    bus1.oY,    0);
        checkOutput("rst_oEdge_round", bus1.oEdge, 0);
        checkOutput("rst_oEOF_round",  bus1.oEOF,  0);
`ifdef THRESHOLD_EN
        checkOutput("rst_oBin_trunc",  bus0.oBin,  0);
        checkOutput("rst_oBin_round",  bus1.oBin,  0);
`endif
    endtask

    task automatic doReset(input int cycles);
        iRST       = 1'b1;
        bus0.iSOF  = 1'b0;
        bus0.iDVAL = 1'b0;
        bus0.iDATA = '0;
        repeat (cycles) begin
            @(posedge iCLK);
            #1;
        end
        q.delete();
        mx = 0;
        my = 0;
        checkReset();
        iRST = 1'b0;
    endtask

    task automatic checkCycle();
        logic expV;
        expT  e;
        expV = (q.size() > 0) && (q[0].due == cyc);
        checkOutput("oDVAL_trunc", bus0.oDVAL, expV);
        checkOutput("oDVAL_round", bus1.oDVAL, expV);
        if (expV) begin
            e = q.pop_front();
            checkOutput("oGrey_trunc", bus0.oGrey, e.g0);
            checkOutput("oGrey_round", bus1.oGrey, e.g1);
            checkOutput("oX_trunc",    bus0.oX,    e.ex);
            checkOutput("oY_trunc",    bus0.oY,    e.ey);
            checkOutput("oX_round",    bus1.oX,    e.ex);
            checkOutput("oY_round",    bus1.oY,    e.ey);
            checkOutput("oEdge_trunc", bus0.oEdge, e.onEdge);
            checkOutput("oEdge_round", bus1.oEdge, e.onEdge);
            checkOutput("oEOF_trunc",  bus0.oEOF,  e.eof);
            checkOutput("oEOF_round",  bus1.oEOF,  e.eof);
`ifdef THRESHOLD_EN
            checkOutput("oBin_trunc",  bus0.oBin,  e.bin0);
            checkOutput("oBin_round",  bus1.oBin,  e.bin1);
`endif
        end
    endtask

    initial begin
        forever begin
            @(negedge iCLK);
            if (monitorOn) checkCycle();
        end
    end

    initial begin
        iRST       = 1'b1;
        bus0.iSOF  = 1'b0;
        bus0.iDVAL = 1'b0;
        bus0.iDATA = '0;
`ifdef THRESHOLD_EN
        bus0.iTHRESH = thresh;
`endif
        doReset(3);
        monitorOn = 1'b1;

        // Constant frame, then a saturated frame relying on the counters having wrapped.
        sendFrame(0, 0, -1, -1, 1'b1);
        sendFrame(2, 3, -1, -1, 1'b0);

        // Directed quads (804 sum, 1-1-1-2, 1-1-1-3) gapless and with gaps.
        sendFrame(1, 0, -1, -1, 1'b1);
        sendFrame(1, 2, -1, -1, 1'b1);

        // Start-of-frame mid-frame, with and without a pixel on the same cycle.
        sendFrame(1, 0, 4, 3, 1'b1);
        sendFrame(1, 0, -1, -1, 1'b1);
        sendFrame(1, 1, 2, 4, 1'b1);
        applyStimulus(1'b1, 1'b0, 12'($urandom));
        sendFrame(1, 1, -1, -1, 1'b0);

        // Reset in row 3 with a quad still in flight, then a clean restart.
        sendFrame(1, 0, 2, 3, 1'b1);
        doReset(1);
        sendFrame(1, 0, -1, -1, 1'b0);

`ifdef THRESHOLD_EN
        sendFrame(3, 1, -1, -1, 1'b1);
`endif

        repeat (5) applyStimulus(1'b0, 1'b0, 12'd0);
        checkOutput("drain_pending", q.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
